// File: rtl/spm_init_pkg.sv
// Shared types for the SPM bulk initiator: command ops, FSM states, SPM port structs
// and the byte-address to index/tag mapping.
package spm_init_pkg;

    localparam int unsigned XLEN               = 64;
    localparam int unsigned DATA_WIDTH         = XLEN;
    localparam int unsigned WORD_BYTES         = DATA_WIDTH / 8;
    localparam int unsigned WORD_SHIFT         = $clog2(WORD_BYTES);
    localparam int unsigned DCACHE_INDEX_WIDTH = 12;
    localparam int unsigned DCACHE_TAG_WIDTH   = 44;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'd0,
        OP_ZERO    = 2'd1,
        OP_READ    = 2'd2,
        OP_ILLEGAL = 2'd3
    } spm_init_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StReq,
        StVerify,
        StOut,
        StDone
    } spm_init_state_e;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [DATA_WIDTH-1:0]         data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [WORD_BYTES-1:0]         data_be;
        logic [1:0]                    data_size;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic                  data_gnt;
        logic                  data_rvalid;
        logic [DATA_WIDTH-1:0] data_rdata;
    } dcache_req_o_t;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] index;
        logic [DCACHE_TAG_WIDTH-1:0]   tag;
    } spm_addr_t;

    // Low bits select the byte within a way; the way number lands in the low tag bits.
    function automatic spm_addr_t spm_addr_map(input logic [31:0] addr,
                                               input int unsigned idx_w,
                                               input int unsigned way_w);
        spm_addr_t   m;
        logic [31:0] idx_mask;
        logic [31:0] way_mask;
        idx_mask = (32'd1 << idx_w) - 32'd1;
        way_mask = (32'd1 << way_w) - 32'd1;
        m.index  = DCACHE_INDEX_WIDTH'(addr & idx_mask);
        m.tag    = DCACHE_TAG_WIDTH'((addr >> idx_w) & way_mask);
        return m;
    endfunction

endpackage

// File: rtl/spm_bulk_init.sv
// Bulk write / zero-fill / read-out master for the SPM port, one word access at a time.
// Optional SPM_INIT_READBACK_EN: read back every written word and stop on a mismatch.
module spm_bulk_init
    import spm_init_pkg::*;
#(
    parameter int unsigned NR_WAYS       = 4,
    parameter int unsigned SPM_IDX_WIDTH = 12,
    parameter int unsigned LEN_WIDTH     = 16,
    localparam int unsigned AW           = SPM_IDX_WIDTH + $clog2(NR_WAYS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [AW-1:0]         cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic                  wdata_valid_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  wdata_ready_o,
    output logic                  rdata_valid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    input  logic                  rdata_ready_i,
    input  logic                  abort_i,
    output dcache_req_i_t         spm_req_o,
    input  dcache_req_o_t         spm_rsp_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [AW-1:0]         err_addr_o
);

    localparam int unsigned EW = AW + LEN_WIDTH + 1;

    spm_init_state_e       r_state, w_state_nxt;
    spm_init_op_e          r_op, w_op_nxt;
    logic [AW-1:0]         r_addr, w_addr_nxt;
    logic [LEN_WIDTH-1:0]  r_rem, w_rem_nxt;
    logic [DATA_WIDTH-1:0] r_buf, w_buf_nxt;
    logic                  r_error, w_error_nxt;
    logic [AW-1:0]         r_err_addr, w_err_addr_nxt;
    logic                  r_abort_pend, w_abort_pend_nxt;

    logic [EW-1:0] w_cmd_end;
    logic [EW-1:0] w_limit;
    logic          w_cmd_ok;
    logic          w_abort;
    logic          w_req_ack;
    logic          w_advance;
    spm_addr_t     w_map;

    assign w_cmd_end = EW'(cmd_addr_i) + (EW'(cmd_len_i) << WORD_SHIFT);
    assign w_limit   = EW'(NR_WAYS) << SPM_IDX_WIDTH;
    assign w_cmd_ok  = (cmd_addr_i[WORD_SHIFT-1:0] == '0) && (cmd_len_i != '0) &&
                       (cmd_op_i != OP_ILLEGAL) && (w_cmd_end <= w_limit);

    // An abort seen mid-ack is remembered and acted on at the next word boundary.
    assign w_abort   = abort_i | r_abort_pend;
    assign w_req_ack = (r_op == OP_READ) ? spm_rsp_i.data_rvalid : spm_rsp_i.data_gnt;
    assign w_map     = spm_addr_map(32'(r_addr), SPM_IDX_WIDTH, $clog2(NR_WAYS));

    always_comb begin
        w_state_nxt      = r_state;
        w_op_nxt         = r_op;
        w_addr_nxt       = r_addr;
        w_rem_nxt        = r_rem;
        w_buf_nxt        = r_buf;
        w_error_nxt      = r_error;
        w_err_addr_nxt   = r_err_addr;
        w_abort_pend_nxt = r_abort_pend | abort_i;
        w_advance        = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_abort_pend_nxt = 1'b0;
                if (cmd_valid_i) begin
                    w_op_nxt    = spm_init_op_e'(cmd_op_i);
                    w_addr_nxt  = cmd_addr_i;
                    w_rem_nxt   = cmd_len_i;
                    w_buf_nxt   = '0;
                    w_error_nxt = 1'b0;
                    if (!w_cmd_ok) begin
                        w_error_nxt    = 1'b1;
                        w_err_addr_nxt = cmd_addr_i;
                        w_state_nxt    = StDone;
                    end else if (cmd_op_i == OP_WRITE) begin
                        w_state_nxt = StFetch;
                    end else begin
                        w_state_nxt = StReq;
                    end
                end
            end
            StFetch: begin
                if (w_abort) begin
                    w_state_nxt = StDone;
                end else if (wdata_valid_i) begin
                    w_buf_nxt   = wdata_i;
                    w_state_nxt = StReq;
                end
            end
            StReq: begin
                if (w_req_ack) begin
                    if (r_op == OP_READ) begin
                        w_buf_nxt   = spm_rsp_i.data_rdata;
                        w_state_nxt = StOut;
                    end else begin
`ifdef SPM_INIT_READBACK_EN
                        w_state_nxt = StVerify;
`else
                        w_advance   = 1'b1;
`endif
                    end
                end
            end
`ifdef SPM_INIT_READBACK_EN
            StVerify: begin
                if (spm_rsp_i.data_rvalid) begin
                    if (spm_rsp_i.data_rdata != r_buf) begin
                        w_error_nxt    = 1'b1;
                        w_err_addr_nxt = r_addr;
                        w_state_nxt    = StDone;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
`endif
            StOut: begin
                if (rdata_ready_i) begin
                    w_advance = 1'b1;
                end
            end
            StDone: begin
                w_abort_pend_nxt = 1'b0;
                w_state_nxt      = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase

        if (w_advance) begin
            w_addr_nxt = r_addr + AW'(WORD_BYTES);
            w_rem_nxt  = r_rem - LEN_WIDTH'(1);
            if (r_rem == LEN_WIDTH'(1) || w_abort) begin
                w_state_nxt = StDone;
            end else if (r_op == OP_WRITE) begin
                w_state_nxt = StFetch;
            end else begin
                w_state_nxt = StReq;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= StIdle;
            r_op         <= OP_WRITE;
            r_addr       <= '0;
            r_rem        <= '0;
            r_buf        <= '0;
            r_error      <= 1'b0;
            r_err_addr   <= '0;
            r_abort_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_op         <= w_op_nxt;
            r_addr       <= w_addr_nxt;
            r_rem        <= w_rem_nxt;
            r_buf        <= w_buf_nxt;
            r_error      <= w_error_nxt;
            r_err_addr   <= w_err_addr_nxt;
            r_abort_pend <= w_abort_pend_nxt;
        end
    end

    always_comb begin
        spm_req_o = '0;
        if (r_state == StReq || r_state == StVerify) begin
            spm_req_o.address_index = w_map.index;
            spm_req_o.address_tag   = w_map.tag;
            spm_req_o.data_wdata    = r_buf;
            spm_req_o.data_req      = 1'b1;
            spm_req_o.data_we       = (r_state == StReq) && (r_op != OP_READ);
            spm_req_o.data_be       = '1;
            spm_req_o.data_size     = 2'b11;
            spm_req_o.tag_valid     = 1'b1;
        end
    end

    assign cmd_ready_o   = (r_state == StIdle);
    assign busy_o        = (r_state != StIdle);
    assign done_o        = (r_state == StDone);
    assign wdata_ready_o = (r_state == StFetch);
    assign rdata_valid_o = (r_state == StOut);
    assign rdata_o       = r_buf;
    assign error_o       = r_error;
    assign err_addr_o    = r_err_addr;

endmodule

// File: tb/tb_spm_bulk_init.sv
// Self-checking bench for spm_bulk_init: behavioural SPM responder, access scoreboard,
// command vector table and hand-written corner sequences.
module tb_spm_bulk_init;
    import spm_init_pkg::*;

    localparam int unsigned AW = 14;
`ifdef SPM_INIT_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid, cmd_ready;
    logic [1:0]      cmd_op;
    logic [AW-1:0]   cmd_addr;
    logic [15:0]     cmd_len;
    logic            wdata_valid, wdata_ready;
    logic [63:0]     wdata;
    logic            rdata_valid, rdata_ready;
    logic [63:0]     rdata;
    logic            abort;
    dcache_req_i_t   spm_req;
    dcache_req_o_t   spm_rsp;
    logic            busy, done, error;
    logic [AW-1:0]   err_addr;

    always #5 clk = ~clk;

    spm_bulk_init dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_addr_i   (cmd_addr),
        .cmd_len_i    (cmd_len),
        .wdata_valid_i(wdata_valid),
        .wdata_i      (wdata),
        .wdata_ready_o(wdata_ready),
        .rdata_valid_o(rdata_valid),
        .rdata_o      (rdata),
        .rdata_ready_i(rdata_ready),
        .abort_i      (abort),
        .spm_req_o    (spm_req),
        .spm_rsp_i    (spm_rsp),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .err_addr_o   (err_addr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] init_word(input int i);
        if (i == 2047) return 64'hCA11AB1E_BADCAB1E;
        return 64'hC0DE_0000_0000_0000 | 64'(i);
    endfunction

    function automatic logic [63:0] wword(input int i);
        return 64'h1111_1111_1111_1111 * 64'(i + 1);
    endfunction

    // Responder: acks after wait_n cycles of a held request
    int            wait_n = 0;
    int            wait_cnt;
    logic          corrupt_en;
    logic [AW-1:0] corrupt_addr;
    logic [63:0]   mem [0:2047];
    logic [AW-1:0] req_addr;
    logic          rsp_ack;

    assign req_addr = {spm_req.address_tag[1:0], spm_req.address_index};
    assign rsp_ack  = spm_req.data_req && (wait_cnt >= wait_n);

    always_comb begin
        spm_rsp = '0;
        if (rsp_ack) begin
            if (spm_req.data_we) begin
                spm_rsp.data_gnt = 1'b1;
            end else begin
                spm_rsp.data_rvalid = 1'b1;
                spm_rsp.data_rdata  = mem[req_addr[AW-1:3]] ^
                    ((corrupt_en && req_addr == corrupt_addr) ? 64'h1 : 64'h0);
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 0;
            for (int i = 0; i < 2048; i++) mem[i] <= init_word(i);
        end else begin
            if (rsp_ack) wait_cnt <= 0;
            else if (spm_req.data_req) wait_cnt <= wait_cnt + 1;
            else wait_cnt <= 0;
            if (rsp_ack && spm_req.data_we) mem[req_addr[AW-1:3]] <= spm_req.data_wdata;
        end
    end

    // Scoreboard
    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [63:0]   data;
    } acc_t;

    acc_t        exp_q[$];
    logic [63:0] rd_q[$];
    logic [63:0] model [0:2047];
    int          n_access    = 0;
    int          n_done      = 0;
    int          n_gap_cyc   = 0;
    int          n_gap_req   = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (done) n_done++;
            if (wdata_ready && !wdata_valid) begin
                n_gap_cyc++;
                if (spm_req.data_req) n_gap_req++;
            end
            if (rsp_ack) begin
                acc_t e;
                bit   ok;
                n_access++;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_access", 64'(req_addr), 64'h0);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (req_addr == e.addr) && (spm_req.data_we == e.we) &&
                         (!e.we || spm_req.data_wdata == e.data) &&
                         (spm_req.data_be == 8'hFF) && spm_req.tag_valid &&
                         !spm_req.kill_req && (spm_req.address_tag[43:2] == '0);
                    chk(ok, "access", {spm_req.data_wdata[47:0], 1'b0, spm_req.data_we,
                        req_addr}, {e.data[47:0], 1'b0, e.we, e.addr});
                end
            end
            if (rdata_valid && rdata_ready) begin
                if (rd_q.size() == 0) chk(1'b0, "unexpected_rdata", rdata, 64'h0);
                else begin
                    logic [63:0] er;
                    er = rd_q.pop_front();
                    chk(rdata === er, "rdata", rdata, er);
                end
            end
        end
    end

    task automatic push_exp(input logic [1:0] op, input logic [AW-1:0] addr, input int n);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] a;
            logic [63:0]   d;
            a = addr + AW'(8 * i);
            if (op == OP_READ) begin
                exp_q.push_back('{a, 1'b0, 64'h0});
                rd_q.push_back(model[a[AW-1:3]]);
            end else begin
                d = (op == OP_WRITE) ? wword(i) : 64'h0;
                exp_q.push_back('{a, 1'b1, d});
                model[a[AW-1:3]] = d;
                if (RB) exp_q.push_back('{a, 1'b0, 64'h0});
            end
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [15:0] len);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_len   = len;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Feeds write words (gap idle cycles before each) until done_o or budget expiry.
    task automatic run(input int gap, input int budget, output bit got);
        int wi;
        int gcnt;
        bit hs;
        wi   = 0;
        gcnt = 0;
        got  = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            wdata_valid = (gcnt >= gap);
            wdata       = wword(wi);
            @(negedge clk);
            hs = wdata_valid && wdata_ready;
            if (done) got = 1'b1;
            @(posedge clk); #1;
            if (hs) begin
                wi++;
                gcnt = 0;
            end else begin
                gcnt++;
            end
        end
        wdata_valid = 1'b0;
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [15:0]   len;
        int            wait_n;
        int            gap;
        bit            rej;
    } vec_t;

    vec_t vecs[9];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit          got;
        bit          stable;
        int          nacc0;
        int          ndone0;
        int          exp_nacc;
        logic [63:0] held;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b1; abort = 1'b0;
        corrupt_en = 1'b0; corrupt_addr = '0;
        for (int i = 0; i < 2048; i++) model[i] = init_word(i);

        vecs[0] = '{OP_ZERO,  14'h1000, 16'd4, 1, 0, 1'b0};
        vecs[1] = '{OP_WRITE, 14'h0000, 16'd2, 0, 3, 1'b0};
        vecs[2] = '{OP_READ,  14'h0000, 16'd2, 2, 0, 1'b0};
        vecs[3] = '{OP_ZERO,  14'h3FF8, 16'd1, 0, 0, 1'b0};
        vecs[4] = '{OP_ZERO,  14'h3FF8, 16'd2, 0, 0, 1'b1};
        vecs[5] = '{OP_WRITE, 14'h0004, 16'd1, 0, 0, 1'b1};
        vecs[6] = '{OP_READ,  14'h0100, 16'd0, 0, 0, 1'b1};
        vecs[7] = '{2'd3,     14'h0000, 16'd1, 0, 0, 1'b1};
        vecs[8] = '{OP_WRITE, 14'h2000, 16'd3, 2, 0, 1'b0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(cmd_ready === 1'b1 && busy === 1'b0 && done === 1'b0 && error === 1'b0,
            "reset_ctrl", {cmd_ready, busy, done, error}, 64'h8);
        chk(spm_req === '0, "reset_req", {spm_req.data_req, spm_req.data_be}, 64'h0);
        chk(err_addr === '0 && rdata_valid === 1'b0 && wdata_ready === 1'b0 && rdata === '0,
            "reset_misc", {err_addr, rdata_valid, wdata_ready}, 64'h0);

        // Read of the last word of way 3, with the consumer stalling for 5 cycles
        wait_n = 1;
        rdata_ready = 1'b0;
        ndone0 = n_done;
        push_exp(OP_READ, 14'h3FF8, 1);
        issue(OP_READ, 14'h3FF8, 16'd1);
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (rdata_valid) got = 1'b1;
        end
        chk(got, "rd_hold_valid_seen", {63'h0, got}, 64'h1);
        held   = rdata;
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!rdata_valid || rdata !== held || done) stable = 1'b0;
        end
        chk(stable, "rd_hold_stable", rdata, held);
        chk(held === 64'hCA11AB1E_BADCAB1E, "rd_disabled_way_passthrough", held,
            64'hCA11AB1E_BADCAB1E);
        @(posedge clk); #1 rdata_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk(done === 1'b1 && error === 1'b0, "rd_done_after_handshake", {done, error}, 64'h2);
        @(posedge clk); #1;
        chk(n_done - ndone0 == 1, "rd_done_count", 64'(n_done - ndone0), 64'h1);

        for (int v = 0; v < 9; v++) begin
            wait_n   = vecs[v].wait_n;
            nacc0    = n_access;
            ndone0   = n_done;
            exp_nacc = vecs[v].rej ? 0 :
                       int'(vecs[v].len) * ((RB && vecs[v].op != OP_READ) ? 2 : 1);
            if (!vecs[v].rej) push_exp(vecs[v].op, vecs[v].addr, int'(vecs[v].len));
            issue(vecs[v].op, vecs[v].addr, vecs[v].len);
            run(vecs[v].gap, 300, got);
            chk(got, $sformatf("vec%0d_done", v), {63'h0, got}, 64'h1);
            chk(error === vecs[v].rej, $sformatf("vec%0d_error", v), {63'h0, error},
                {63'h0, vecs[v].rej});
            if (vecs[v].rej)
                chk(err_addr === vecs[v].addr, $sformatf("vec%0d_err_addr", v),
                    64'(err_addr), 64'(vecs[v].addr));
            chk(n_access - nacc0 == exp_nacc, $sformatf("vec%0d_accesses", v),
                64'(n_access - nacc0), 64'(exp_nacc));
            chk(n_done - ndone0 == 1, $sformatf("vec%0d_done_pulses", v),
                64'(n_done - ndone0), 64'h1);
            chk(exp_q.size() == 0 && rd_q.size() == 0, $sformatf("vec%0d_drained", v),
                64'(exp_q.size() + rd_q.size()), 64'h0);
        end
        chk(n_gap_cyc > 0 && n_gap_req == 0, "no_req_during_wdata_gap", 64'(n_gap_req),
            64'h0);

        // Abort pulsed while word 2 of 8 waits for its grant
        wait_n = 3;
        nacc0  = n_access;
        push_exp(OP_ZERO, 14'h0000, 2);
        issue(OP_ZERO, 14'h0000, 16'd8);
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (spm_req.data_req && spm_req.data_we && req_addr == 14'h0008) got = 1'b1;
        end
        chk(got, "abort_reach_word2", {63'h0, got}, 64'h1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        run(0, 200, got);
        chk(got && error === 1'b0, "abort_done_no_error", {got, error}, 64'h2);
        chk(n_access - nacc0 == (RB ? 4 : 2), "abort_accesses", 64'(n_access - nacc0),
            RB ? 64'h4 : 64'h2);
        chk(exp_q.size() == 0, "abort_drained", 64'(exp_q.size()), 64'h0);

`ifdef SPM_INIT_READBACK_EN
        // Readback of word 1 is corrupted: stop there with the error recorded
        wait_n       = 0;
        corrupt_addr = 14'h0008;
        corrupt_en   = 1'b1;
        nacc0        = n_access;
        push_exp(OP_WRITE, 14'h0000, 2);
        issue(OP_WRITE, 14'h0000, 16'd3);
        run(0, 200, got);
        chk(got && error === 1'b1, "rb_error", {got, error}, 64'h3);
        chk(err_addr === 14'h0008, "rb_err_addr", 64'(err_addr), 64'h8);
        chk(n_access - nacc0 == 4, "rb_accesses", 64'(n_access - nacc0), 64'h4);
        chk(exp_q.size() == 0, "rb_drained", 64'(exp_q.size()), 64'h0);
        corrupt_en = 1'b0;
`endif

        // Reset while a request waits for its ack
        wait_n = 10;
        issue(OP_ZERO, 14'h0100, 16'd4);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (spm_req.data_req) got = 1'b1;
        end
        chk(got, "rst_mid_req_seen", {63'h0, got}, 64'h1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk(spm_req.data_req === 1'b0 && cmd_ready === 1'b1 && busy === 1'b0,
            "rst_mid_access", {spm_req.data_req, cmd_ready, busy}, 64'h2);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
